// File: rtl/usb_pkg.sv
// Shared USB device definitions: buffer sizing, PID codes and received-packet kinds.
package usb_pkg;

    localparam int USB_BUFFER_DEPTH = 64;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        RX_NONE,
        RX_OUT,
        RX_IN,
        RX_DATA0,
        RX_DATA1,
        RX_ACK,
        RX_NAK,
        RX_STALL
    } rx_packet_t;

endpackage

// File: rtl/usb_buffer_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered read port.
module usb_buffer_ram #(
    parameter  int DEPTH  = 64,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read register holds its value when re is low (buffer empty).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/usb_data_buffer.sv
// Single-clock byte FIFO shared by the USB RX/TX paths and the AHB-lite slave.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter  int DEPTH = USB_BUFFER_DEPTH,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             flush,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             get_tx_packet_data,
    input  logic             clear,
    output logic [7:0]       rx_data,
    output logic [7:0]       tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             overflow
);

    localparam int AW     = $clog2(DEPTH);
    localparam int DATA_W = 8;

    logic [OCC_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
    logic              push_req, pop_req, wipe, empty, full;
    logic              do_push, do_pop, ovf_set;
    logic [DATA_W-1:0] wdata, head;

    always_comb begin
        push_req = store_rx_packet_data | store_tx_data;
        pop_req  = get_rx_data | get_tx_packet_data;
        // RX byte wins when both producers strobe together; the TX byte is dropped silently.
        wdata    = store_rx_packet_data ? rx_packet_data : tx_data;
        wipe     = flush | clear;
        empty    = (buffer_occupancy == '0);
        full     = (buffer_occupancy == OCC_W'(DEPTH));
        do_pop   = pop_req && !empty && !wipe;
        // When full, a same-cycle pop frees the slot the push then lands in.
        do_push  = push_req && (!full || pop_req) && !wipe;
        ovf_set  = push_req && full && !pop_req && !wipe;
        wptr_nxt = wipe ? '0 : (do_push ? wptr + OCC_W'(1) : wptr);
        rptr_nxt = wipe ? '0 : (do_pop  ? rptr + OCC_W'(1) : rptr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr             <= '0;
            rptr             <= '0;
            buffer_occupancy <= '0;
            overflow         <= 1'b0;
        end else begin
            wptr             <= wptr_nxt;
            rptr             <= rptr_nxt;
            buffer_occupancy <= wptr_nxt - rptr_nxt;
            if (clear)
                overflow <= 1'b0;
            else if (ovf_set)
                overflow <= 1'b1;
        end
    end

    usb_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (do_push),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (!empty),
        .raddr (rptr[AW-1:0]),
        .rdata (head)
    );

    assign rx_data        = head;
    assign tx_packet_data = head;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer against a queue-based reference model.
module tb_usb_data_buffer;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       store_rx_packet_data, store_tx_data, get_rx_data, get_tx_packet_data;
    logic       flush, clear;
    logic [7:0] rx_packet_data, tx_data;
    logic [7:0] rx_data, tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic       exp_ovf;
    logic [7:0] exp_rx;

    usb_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .flush                (flush),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .clear                (clear),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
        exp_rx  = 8'h00;
    endtask

    // Drive one cycle of strobes, advance the model at the edge, release strobes 1ns later.
    task automatic step(input logic srx, input logic [7:0] rb, input logic stx, input logic [7:0] tb,
                        input logic grx, input logic gtx, input logic fl, input logic cl);
        logic pop, push;
        logic [7:0] b;
        store_rx_packet_data = srx; rx_packet_data = rb;
        store_tx_data = stx; tx_data = tb;
        get_rx_data = grx; get_tx_packet_data = gtx;
        flush = fl; clear = cl;
        @(posedge clk);
        if (q.size() != 0) exp_rx = q[0];
        pop  = grx | gtx;
        push = srx | stx;
        b    = srx ? rb : tb;
        if (fl || cl) begin
            q.delete();
            if (cl) exp_ovf = 1'b0;
        end else if (q.size() == DEPTH) begin
            if (pop) begin
                void'(q.pop_front());
                if (push) q.push_back(b);
            end else if (push) begin
                exp_ovf = 1'b1;
            end
        end else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (push) q.push_back(b);
        end
        #1;
        store_rx_packet_data = 0; store_tx_data = 0;
        get_rx_data = 0; get_tx_packet_data = 0;
        flush = 0; clear = 0;
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        step(1, b, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        push_rx(8'h5A); push_rx(8'h6B); idle();
        @(negedge clk);
        n_rst = 0;
        model_reset();
        #1;
        n_checks++;
        if (buffer_occupancy !== 7'd0) $display("FAIL reset_occ: got %0d want 0", buffer_occupancy);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx: got %h want 00", rx_data);
        else n_pass++;
        @(posedge clk); #1;
        n_rst = 1;
    endtask

    task automatic test_rx_fill_drain();
        for (int i = 0; i < 4; i++) begin
            push_rx(8'(i));
            n_checks++;
            if (buffer_occupancy !== 7'(i + 1)) $display("FAIL fill_occ[%0d]: got %0d want %0d", i, buffer_occupancy, i + 1);
            else n_pass++;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_data !== 8'(i) || rx_data !== exp_rx) $display("FAIL drain_rx[%0d]: got %h want %h", i, rx_data, 8'(i));
            else n_pass++;
            step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
            idle();
        end
        n_checks++;
        if (buffer_occupancy !== 7'd0) $display("FAIL drain_occ: got %0d want 0", buffer_occupancy);
        else n_pass++;
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i <= DEPTH; i++) push_rx(8'(i));
        n_checks++;
        if (buffer_occupancy !== 7'd64) $display("FAIL full_occ: got %0d want 64", buffer_occupancy);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL full_ovf: got %b want 1", overflow);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rx_data !== 8'(i)) $display("FAIL full_drain[%0d]: got %h want %h", i, rx_data, 8'(i));
            else n_pass++;
            step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
            idle();
        end
        n_checks++;
        if (buffer_occupancy !== 7'd0 || overflow !== 1'b1)
            $display("FAIL full_end: got occ %0d ovf %b want occ 0 ovf 1", buffer_occupancy, overflow);
        else n_pass++;
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL clear_ovf: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int errs;
        int max_occ;
        int lens[4] = '{48, 48, 40, 40};
        errs = 0;
        max_occ = 0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < lens[ph]; i++) begin
                if (ph % 2 == 0) begin
                    push_rx(8'($urandom));
                end else begin
                    idle();
                    if (rx_data !== exp_rx) errs++;
                    step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
                end
                if (buffer_occupancy !== 7'(q.size())) errs++;
                if (ph >= 2 && int'(buffer_occupancy) > max_occ) max_occ = int'(buffer_occupancy);
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL wrap_order: got %0d errors want 0", errs);
        else n_pass++;
        n_checks++;
        if (max_occ != 40) $display("FAIL wrap_max_occ: got %0d want 40", max_occ);
        else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) push_rx(8'($urandom));
        n_checks++;
        if (buffer_occupancy !== 7'd10) $display("FAIL flush_pre_occ: got %0d want 10", buffer_occupancy);
        else n_pass++;
        step(1, 8'hAA, 0, 8'h00, 0, 0, 1, 0);
        n_checks++;
        if (buffer_occupancy !== 7'd0) $display("FAIL flush_occ: got %0d want 0", buffer_occupancy);
        else n_pass++;
        push_rx(8'hBB);
        n_checks++;
        if (buffer_occupancy !== 7'd1) $display("FAIL flush_next_occ: got %0d want 1", buffer_occupancy);
        else n_pass++;
        idle();
        n_checks++;
        if (rx_data !== 8'hBB) $display("FAIL flush_next_rx: got %h want bb", rx_data);
        else n_pass++;
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    endtask

    task automatic test_tx_simultaneous();
        step(0, 8'h00, 1, 8'h11, 0, 0, 0, 0);
        step(0, 8'h00, 1, 8'h22, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (tx_packet_data !== 8'h11) $display("FAIL tx_first: got %h want 11", tx_packet_data);
        else n_pass++;
        step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        idle();
        n_checks++;
        if (tx_packet_data !== 8'h22) $display("FAIL tx_second: got %h want 22", tx_packet_data);
        else n_pass++;
        step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
        n_checks++;
        if (buffer_occupancy !== 7'd0) $display("FAIL dual_pop_occ: got %0d want 0", buffer_occupancy);
        else n_pass++;
        step(1, 8'h33, 0, 8'h00, 1, 0, 0, 0);
        n_checks++;
        if (buffer_occupancy !== 7'd1) $display("FAIL empty_pushpop_occ: got %0d want 1", buffer_occupancy);
        else n_pass++;
        idle();
        n_checks++;
        if (rx_data !== 8'h33) $display("FAIL empty_pushpop_rx: got %h want 33", rx_data);
        else n_pass++;
        step(1, 8'h44, 1, 8'h55, 0, 0, 0, 0);
        step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        idle();
        n_checks++;
        if (buffer_occupancy !== 7'd1 || rx_data !== 8'h44)
            $display("FAIL dual_push: got occ %0d rx %h want occ 1 rx 44", buffer_occupancy, rx_data);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL dual_push_ovf: got %b want 0", overflow);
        else n_pass++;
        while (q.size() < DEPTH) push_rx(8'($urandom));
        step(1, 8'hCC, 0, 8'h00, 1, 0, 0, 0);
        n_checks++;
        if (buffer_occupancy !== 7'd64 || overflow !== 1'b0)
            $display("FAIL full_pushpop: got occ %0d ovf %b want occ 64 ovf 0", buffer_occupancy, overflow);
        else n_pass++;
        idle();
        n_checks++;
        if (rx_data !== 8'h55 && rx_data !== exp_rx) $display("FAIL full_pushpop_rx: got %h want %h", rx_data, exp_rx);
        else n_pass++;
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
            if (buffer_occupancy !== 7'(q.size()) || overflow !== exp_ovf ||
                rx_data !== exp_rx || tx_packet_data !== exp_rx) begin
                if (errs < 5)
                    $display("FAIL random[%0d]: got occ %0d ovf %b rx %h tx %h want occ %0d ovf %b rx %h",
                             c, buffer_occupancy, overflow, rx_data, tx_packet_data, q.size(), exp_ovf, exp_rx);
                errs++;
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL random_total: got %0d mismatching cycles want 0", errs);
        else n_pass++;
    endtask

    initial begin
        store_rx_packet_data = 0; store_tx_data = 0;
        get_rx_data = 0; get_tx_packet_data = 0;
        flush = 0; clear = 0;
        rx_packet_data = 0; tx_data = 0;
        n_rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 n_rst = 1;
        test_reset();
        test_rx_fill_drain();
        test_full_overflow();
        test_wrap();
        test_flush();
        test_tx_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
